// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with start/done handshake, status flags, shift-add multiplier and sticky halt
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] accum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             halted
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDO = 4'b0001;
    localparam logic [3:0] OP_LDA = 4'b0010;
    localparam logic [3:0] OP_STO = 4'b0011;
    localparam logic [3:0] OP_PRE = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_LDM = 4'b0110;
    localparam logic [3:0] OP_ADN = 4'b0111;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_DEC = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_CLR = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_AND = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   c_result;
    logic               c_carry;
    logic               c_ovf;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   imm;
    logic [WIDTH:0]     sum_ext;
    logic               is_add;
    logic               is_sub;
    logic [2*WIDTH-1:0] prod_next;

    // Single-cycle datapath; add and subtract share one extended sum for carry/borrow.
    always_comb begin
        c_result = accum;
        c_carry  = 1'b0;
        c_ovf    = 1'b0;
        addend   = '0;
        is_add   = 1'b0;
        is_sub   = 1'b0;
        sum_ext  = '0;
        imm      = '0;
        imm[IMM_W-1:0] = alu_in[IMM_W-1:0];
        case (op)
            OP_NOP, OP_STO, OP_LDM, OP_HLT, OP_MUL: c_result = accum;
            OP_LDO, OP_LDA, OP_PRE, OP_JMP:         c_result = alu_in;
            OP_ADD: begin addend = alu_in;       is_add = 1'b1; end
            OP_ADN: begin addend = imm;          is_add = 1'b1; end
            OP_INC: begin addend = WIDTH'(1);    is_add = 1'b1; end
            OP_DEC: begin addend = WIDTH'(1);    is_sub = 1'b1; end
            OP_SUB: begin addend = alu_in;       is_sub = 1'b1; end
            OP_CLR: c_result = '0;
            OP_AND: c_result = accum & alu_in;
            default: c_result = accum;
        endcase
        if (is_add) begin
            sum_ext  = {1'b0, accum} + {1'b0, addend};
            c_result = sum_ext[WIDTH-1:0];
            c_carry  = sum_ext[WIDTH];
            c_ovf    = (accum[MSB] == addend[MSB]) && (c_result[MSB] != accum[MSB]);
        end else if (is_sub) begin
            sum_ext  = {1'b0, accum} - {1'b0, addend};
            c_result = sum_ext[WIDTH-1:0];
            c_carry  = sum_ext[WIDTH];
            c_ovf    = (accum[MSB] != addend[MSB]) && (c_result[MSB] != accum[MSB]);
        end
    end

    assign prod_next = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            halted <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !halted) begin
                        if (op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, accum};
                            mplier <= alu_in;
                            prod   <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            result <= c_result;
                            carry  <= c_carry;
                            ovf    <= c_ovf;
                            zero   <= (c_result == '0);
                            neg    <= c_result[MSB];
                            done   <= 1'b1;
                            if (op == OP_HLT) halted <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Last iteration publishes the sum including this cycle's partial product.
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= prod_next[WIDTH-1:0];
                        carry  <= |prod_next[2*WIDTH-1:WIDTH];
                        ovf    <= 1'b0;
                        zero   <= (prod_next[WIDTH-1:0] == '0);
                        neg    <= prod_next[MSB];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
